bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Registered round-robin arbiter for the shared 8-bit data bus and 16-bit address bus.
//   Requesters are the control unit, memory, PC and the register-file port group.
//   Issues a one-hot grant that each requester uses as its sole tri-state drive enable.
//   Inserts one dead turnaround cycle between owners, so no two drivers ever overlap.
// PARAMETERS
//   NREQ      4  number of requesters; index 0 = control unit
//   MAX_HOLD  8  max consecutive owned cycles before forced rotation; 0 = never preempt
//   IDW       2  width of gnt_id; must be >= clog2(NREQ)
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     synchronous reset, active low
//   req        in   NREQ  request per requester; held high while bus is wanted
//   lock       in   NREQ  owner's atomic-hold flag; blocks preemption while high
//   gnt        out  NREQ  one-hot grant = drive enable; all zero when bus idle
//   gnt_valid  out  1     OR of gnt
//   gnt_id     out  IDW   binary index of current owner; holds last owner when idle
//   preempt    out  1     1-cycle pulse on forced release of owner
// BEHAVIOUR
//   - All outputs registered. On rst_n=0 at an edge:
//     - gnt=0, gnt_valid=0, gnt_id=0, preempt=0
//     - state=IDLE, hold_cnt=0, rr_ptr=NREQ-1, so requester 0 wins first
//   - FSM states:
//     - IDLE: gnt=0. Any req -> arbitrate -> OWN; gnt is visible the next cycle.
//     - OWN: gnt held while req[owner]=1; hold_cnt += 1 per cycle, saturating.
//       - req[owner]=0 -> TURN.
//       - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and lock[owner]=0 and another req
//         pending -> TURN, with preempt=1 for that one cycle.
//     - TURN: gnt=0 for exactly 1 cycle. Then arbitrate -> OWN if any req, else IDLE.
//   - Arbitration:
//     - Search from rr_ptr+1 upward, wrapping NREQ-1 -> 0; first req wins.
//     - On grant: rr_ptr <= winner, hold_cnt <= 0.
//   - Latencies:
//     - req rise in IDLE at edge N -> gnt at N+1.
//     - Owner drops req at N -> gnt=0 at N+1 (TURN) -> next gnt at N+2.
//   - Only the owner's req and lock bits are examined during OWN. Other reqs are
//     sampled only at arbitration points (IDLE exit, TURN).
//   - lock with req=0: the release wins and lock is ignored.
//   - A lone requester with no competitor is never preempted; hold_cnt saturates.
//   - Preempted owner keeping req high re-enters rotation after all other pending
//     requesters.
//   - Reset mid-grant: gnt clears at that edge; no TURN cycle is inserted.
//   - Invariant: popcount(gnt) <= 1 every cycle. gnt_id matches gnt whenever
//     gnt_valid=1.
// CONFIGURATION
//   - BUS_ARB_FIXED_PRIO_EN defined:
//     - Requester 0 wins every arbitration it participates in, regardless of rr_ptr.
//     - Requester 0 is never preempted.
//     - Requesters 1..NREQ-1 remain round-robin among themselves.
//   - BUS_ARB_FIXED_PRIO_EN undefined:
//     - Pure round-robin across all NREQ requesters; no special-casing.
// TESTING
//   1. Reset: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, gnt_id=0, preempt=0;
//      rst_n=1 -> gnt=4'b0001 one cycle later.
//   2. Rotation: req=4'b1111 held, each owner drops req for 1 cycle after its grant
//      -> grant order 0,1,2,3,0; gnt=0 exactly 1 cycle between owners.
//   3. Preempt: MAX_HOLD=8, req=4'b0011, lock=0, owner 0 holds req -> after 8 owned
//      cycles preempt=1 for 1 cycle, TURN, gnt=4'b0010.
//   4. Lock: same as 3 with lock[0]=1 for 20 cycles -> no preempt, gnt=4'b0001
//      throughout; lock[0]=0 -> preempt on that edge.
//   5. Fixed priority (BUS_ARB_FIXED_PRIO_EN): rr_ptr=0, req=4'b0101 at TURN
//      -> gnt=4'b0001, not 4'b0100.
//   6. Reset mid-grant: gnt=4'b0100, rst_n=0 one cycle -> gnt=0 next edge;
//      release -> requester 0 first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Registered round-robin arbiter for the shared data/address bus.
// Issues a one-hot grant (the requester's tri-state drive enable) and inserts
// one dead turnaround cycle between owners so drivers never overlap.
// Optional feature macro: BUS_ARB_FIXED_PRIO_EN -- requester 0 (control unit)
// always wins arbitration and is never preempted; 1..NREQ-1 stay round-robin.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            preempt
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  // Hold counter only needs to reach MAX_HOLD-1, where it saturates.
  localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic              preempt_q, preempt_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;

  logic              arb_found;
  logic [IDW-1:0]    arb_winner;
  logic              owner_req;
  logic              owner_lock;
  logic              others_pending;
  logic              can_preempt;

  // Requester index reached by stepping 'off' places past 'base', wrapping.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    return IDW'((int'(base) + off) % NREQ);
  endfunction

  // Round-robin search starting just after the last winner.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
`ifdef BUS_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      arb_found  = 1'b1;
      arb_winner = '0;
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        if (!arb_found && (wrap_idx(rr_ptr_q, i) != '0) && req[wrap_idx(rr_ptr_q, i)]) begin
          arb_found  = 1'b1;
          arb_winner = wrap_idx(rr_ptr_q, i);
        end
      end
    end
`else
    for (int i = 1; i <= NREQ; i++) begin
      if (!arb_found && req[wrap_idx(rr_ptr_q, i)]) begin
        arb_found  = 1'b1;
        arb_winner = wrap_idx(rr_ptr_q, i);
      end
    end
`endif
  end

  // Owner-side qualifiers; other requesters only matter as "someone is waiting".
  always_comb begin
    owner_req      = req[gnt_id_q];
    owner_lock     = lock[gnt_id_q];
    others_pending = |(req & ~gnt_q);
    can_preempt    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_SAT) && !owner_lock && others_pending;
`ifdef BUS_ARB_FIXED_PRIO_EN
    if (gnt_id_q == '0) begin
      can_preempt = 1'b0;
    end
`endif
  end

  // Next-state and registered-output computation for the ownership FSM.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE, TURN: begin
        if (arb_found) begin
          state_d    = OWN;
          gnt_d      = NREQ'(1) << arb_winner;
          gnt_id_d   = arb_winner;
          rr_ptr_d   = arb_winner;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      OWN: begin
        if (!owner_req) begin
          // Release wins over lock.
          state_d = TURN;
          gnt_d   = '0;
        end else if (can_preempt) begin
          state_d   = TURN;
          gnt_d     = '0;
          preempt_d = 1'b1;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
      rr_ptr_q    <= IDW'(NREQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (default configuration): the stimulus
// process pushes the hand-computed outputs expected after each clock edge,
// and a monitor pops and compares them just after that edge.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                      input logic [3:0] eg, input logic [1:0] ei, input logic ep,
                      input string tag);
    @(negedge clk);
    rst_n = r;
    req   = rq;
    lock  = lk;
    exp_q.push_back('{gnt: eg, id: ei, pre: ep, tag: tag});
  endtask

  // Monitor: compare one queued expectation per edge, plus the grant invariants.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        started = 1'b1;
        checks++;
        if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || gnt_id !== e.id || preempt !== e.pre) begin
          errors++;
          $display("FAIL %s: got gnt=%b valid=%b id=%0d preempt=%b, want gnt=%b valid=%b id=%0d preempt=%b",
                   e.tag, gnt, gnt_valid, gnt_id, preempt, e.gnt, |e.gnt, e.id, e.pre);
        end else begin
          $display("ok   %s: gnt=%b id=%0d preempt=%b", e.tag, gnt, gnt_id, preempt);
        end
      end
      if (started) begin
        checks++;
        if ($countones(gnt) > 1 || gnt_valid !== (|gnt) ||
            (gnt_valid === 1'b1 && gnt !== (4'b0001 << gnt_id))) begin
          errors++;
          $display("FAIL invariant: got gnt=%b valid=%b id=%0d, want one-hot gnt matching id",
                   gnt, gnt_valid, gnt_id);
        end
      end
    end
  end

  // Watchdog: the directed run is short; expiry means something stalled.
  initial begin
    #50000;
    $display("FAIL timeout: got no finish, want finish before 50000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    lock  = 4'b0000;

    // 1. Reset with all requests high, then requester 0 wins first.
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "reset_a");
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "reset_b");
    step(1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "reset_release");

    // 2. Rotation 0->1->2->3->0 with one dead cycle between owners.
    step(1, 4'b1110, 4'b0000, 4'b0000, 2'd0, 0, "rot_turn0");
    step(1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, "rot_gnt1");
    step(1, 4'b1101, 4'b0000, 4'b0000, 2'd1, 0, "rot_turn1");
    step(1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0, "rot_gnt2");
    step(1, 4'b1011, 4'b0000, 4'b0000, 2'd2, 0, "rot_turn2");
    step(1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0, "rot_gnt3");
    step(1, 4'b0111, 4'b0000, 4'b0000, 2'd3, 0, "rot_turn3");
    step(1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rot_gnt0");

    // Drain to IDLE.
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "drain_turn");
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "drain_idle");

    // 3. Preempt after 8 owned cycles with a competitor pending.
    step(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "pre_gnt0");
    for (int i = 0; i < 7; i++) step(1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 0, "pre_hold");
    step(1, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, "pre_pulse");
    step(1, 4'b0011, 4'b0000, 4'b0010, 2'd1, 0, "pre_gnt1");

    // 4. Lock blocks preemption; unlocking preempts at once (counter saturated).
    step(1, 4'b0001, 4'b0000, 4'b0000, 2'd1, 0, "lock_turn1");
    step(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "lock_gnt0");
    for (int i = 0; i < 20; i++) step(1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 0, "lock_hold");
    step(1, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, "lock_release_pulse");
    step(1, 4'b0011, 4'b0000, 4'b0010, 2'd1, 0, "lock_gnt1");

    // 5. rr_ptr=0 and req=0101 at TURN: plain round-robin picks requester 2.
    step(1, 4'b0001, 4'b0000, 4'b0000, 2'd1, 0, "rr_turn1");
    step(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "rr_gnt0");
    step(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0, "rr_turn0");
    step(1, 4'b0101, 4'b0000, 4'b0100, 2'd2, 0, "rr_pick2");

    // 6. Reset mid-grant: clears immediately, no TURN, requester 0 wins next.
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "mid_turn");
    step(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "mid_gnt2");
    step(0, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0, "mid_reset");
    step(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 0, "mid_release");

    // Lone requester is never preempted; counter saturates silently.
    for (int i = 0; i < 12; i++) step(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "lone_hold");

    // Lock with req low: release wins, then back to IDLE.
    step(1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, "lock_norq_turn");
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "final_idle");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
